// File: rtl/lsu_mem_unit_pkg.sv
// Shared encodings for the load/store unit: funct3 values, response error
// codes, FSM states and the request classification helpers.
package lsu_mem_unit_pkg;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3 encodings (share the size field with loads)
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Access size field, funct3[1:0]
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    // resp_err codes
    localparam logic [1:0] ERR_OK       = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_ILLEGAL  = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

    // funct3 values with no RV32I load/store meaning
    function automatic logic f3_illegal(input logic [2:0] f3);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    // Halfwords need an even offset, words need offset 0
    function automatic logic f3_misaligned(input logic [1:0] size, input logic [1:0] off);
        return ((size == SIZE_H) && off[0]) || ((size == SIZE_W) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_mem_unit_align.sv
// Byte-lane steering: store byte enables / replicated write data, and
// load data extraction with sign or zero extension.
module lsu_align
    import lsu_mem_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext
);

    logic [15:0] rdata_lo;

    // Byte enables: a size-wide mask shifted up to the addressed lane
    always_comb begin
        be = 4'b1111;
        case (funct3[1:0])
            SIZE_B:  be = 4'b0001 << off;
            SIZE_H:  be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
    end

    // Each byte lane carries the store byte/halfword replicated, so whichever
    // lane is enabled sees the right data without a barrel shifter
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign wdata_lane[8*gi +: 8] = (funct3[1:0] == SIZE_B) ? wdata[7:0] :
                                       (funct3[1:0] == SIZE_H) ? wdata[8*(gi%2) +: 8] :
                                                                 wdata[8*gi +: 8];
    end

    // Low 16 bits of the read word shifted right by off bytes
    always_comb begin
        rdata_lo = rdata[15:0];
        case (off)
            2'd0:    rdata_lo = rdata[15:0];
            2'd1:    rdata_lo = rdata[23:8];
            2'd2:    rdata_lo = rdata[31:16];
            default: rdata_lo = {8'h00, rdata[31:24]};
        endcase
    end

    // Extend the extracted byte/halfword; words pass straight through
    always_comb begin
        rdata_ext = 32'h0;
        case (funct3)
            F3_LB:   rdata_ext = {{24{rdata_lo[7]}}, rdata_lo[7:0]};
            F3_LH:   rdata_ext = {{16{rdata_lo[15]}}, rdata_lo};
            F3_LW:   rdata_ext = rdata;
            F3_LBU:  rdata_ext = {24'h0, rdata_lo[7:0]};
            F3_LHU:  rdata_ext = {16'h0, rdata_lo};
            default: rdata_ext = 32'h0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_unit.sv
// MEM-stage load/store unit: captures one request, runs it over a
// req/gnt/rvalid bus with a timeout, and returns a one-cycle response while
// stalling the pipeline in the meantime.
module lsu_mem_unit
    import lsu_mem_unit_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16,
    parameter int DATA_W  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd,
    output logic              stall,
    output logic              resp_valid,
    output logic [4:0]        resp_rd,
    output logic [31:0]       resp_data,
    output logic [1:0]        resp_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [31:0]       bus_rdata
);

    if (DATA_W != 32) begin : g_bad_data_w
        $error("lsu_mem_unit: DATA_W must be 32");
    end

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    lsu_state_e        state_reg, state_next;
    logic              write_reg;
    logic [2:0]        funct3_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [31:0]       wdata_reg;
    logic [4:0]        rd_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [4:0]        resp_rd_reg, resp_rd_next;
    logic [31:0]       resp_data_reg, resp_data_next;
    logic [1:0]        resp_err_reg, resp_err_next;

    logic              accept;
    logic              in_issue;
    logic              timeout_hit;
    logic [3:0]        lane_be;
    logic [31:0]       lane_wdata;
    logic [31:0]       load_data;

    lsu_align u_align (
        .funct3     (funct3_reg),
        .off        (addr_reg[1:0]),
        .wdata      (wdata_reg),
        .rdata      (bus_rdata),
        .be         (lane_be),
        .wdata_lane (lane_wdata),
        .rdata_ext  (load_data)
    );

    assign accept      = (state_reg == ST_IDLE) && req_valid;
    assign in_issue    = (state_reg == ST_ISSUE);
    assign timeout_hit = (TIMEOUT != 0) && (cnt_reg == CNT_W'(TIMEOUT - 1));

    // Next state and the response that will be presented in RESP
    always_comb begin
        state_next     = state_reg;
        resp_rd_next   = resp_rd_reg;
        resp_data_next = resp_data_reg;
        resp_err_next  = resp_err_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req_valid) begin
                    resp_rd_next   = 5'd0;
                    resp_data_next = 32'h0;
                    resp_err_next  = ERR_OK;
                    if (f3_illegal(req_funct3)) begin
                        state_next    = ST_RESP;
                        resp_err_next = ERR_ILLEGAL;
                    end else if (f3_misaligned(req_funct3[1:0], req_addr[1:0])) begin
                        state_next    = ST_RESP;
                        resp_err_next = ERR_MISALIGN;
                    end else begin
                        state_next = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (bus_gnt) begin
                    if (write_reg) begin
                        state_next = ST_RESP;
                    end else if (bus_rvalid) begin
                        state_next     = ST_RESP;
                        resp_rd_next   = rd_reg;
                        resp_data_next = load_data;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end else if (timeout_hit) begin
                    state_next    = ST_RESP;
                    resp_err_next = ERR_TIMEOUT;
                end
            end
            ST_WAIT: begin
                if (bus_rvalid) begin
                    state_next     = ST_RESP;
                    resp_rd_next   = rd_reg;
                    resp_data_next = load_data;
                end else if (timeout_hit) begin
                    state_next    = ST_RESP;
                    resp_err_next = ERR_TIMEOUT;
                end
            end
            default: begin
                // RESP: the still-present request is the one just completed
                state_next = ST_IDLE;
            end
        endcase
    end

    // State, request capture, timeout counter and response registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            write_reg     <= 1'b0;
            funct3_reg    <= 3'b000;
            addr_reg      <= '0;
            wdata_reg     <= 32'h0;
            rd_reg        <= 5'd0;
            cnt_reg       <= '0;
            resp_rd_reg   <= 5'd0;
            resp_data_reg <= 32'h0;
            resp_err_reg  <= ERR_OK;
        end else begin
            state_reg     <= state_next;
            resp_rd_reg   <= resp_rd_next;
            resp_data_reg <= resp_data_next;
            resp_err_reg  <= resp_err_next;
            if (accept) begin
                write_reg  <= req_write;
                funct3_reg <= req_funct3;
                addr_reg   <= req_addr;
                wdata_reg  <= req_wdata;
                rd_reg     <= req_rd;
            end
            if (state_reg == ST_IDLE) begin
                cnt_reg <= '0;
            end else if ((state_reg == ST_ISSUE) || (state_reg == ST_WAIT)) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign stall      = accept || (state_reg == ST_ISSUE) || (state_reg == ST_WAIT);
    assign resp_valid = (state_reg == ST_RESP);
    assign resp_rd    = resp_valid ? resp_rd_reg   : 5'd0;
    assign resp_data  = resp_valid ? resp_data_reg : 32'h0;
    assign resp_err   = resp_valid ? resp_err_reg  : ERR_OK;

    assign bus_req    = in_issue;
    assign bus_we     = in_issue && write_reg;
    assign bus_addr   = in_issue ? {addr_reg[ADDR_W-1:2], 2'b00} : '0;
    assign bus_be     = in_issue ? lane_be : 4'b0000;
    assign bus_wdata  = (in_issue && write_reg) ? lane_wdata : 32'h0;

endmodule

// File: tb/tb_lsu_mem_unit.sv
// Directed bench for lsu_mem_unit: a vector table of single transactions with
// a scripted bus responder, plus hand sequences for timeout and reset-in-WAIT.
module tb_lsu_mem_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        stall, resp_valid;
    logic [4:0]  resp_rd;
    logic [31:0] resp_data;
    logic [1:0]  resp_err;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt, bus_rvalid;
    logic [31:0] bus_rdata;

    // second instance with a short timeout, sharing the request fields
    logic        to_req_valid, to_gnt;
    logic        to_stall, to_resp_valid, to_bus_req, to_bus_we;
    logic [4:0]  to_resp_rd;
    logic [31:0] to_resp_data, to_bus_addr, to_bus_wdata;
    logic [1:0]  to_resp_err;
    logic [3:0]  to_bus_be;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    lsu_mem_unit #(.ADDR_W(32), .TIMEOUT(16), .DATA_W(32)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .stall(stall), .resp_valid(resp_valid), .resp_rd(resp_rd),
        .resp_data(resp_data), .resp_err(resp_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
        .bus_rdata(bus_rdata)
    );

    lsu_mem_unit #(.ADDR_W(32), .TIMEOUT(4), .DATA_W(32)) dut_to (
        .clock(clock), .reset(reset),
        .req_valid(to_req_valid), .req_write(req_write), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .stall(to_stall), .resp_valid(to_resp_valid), .resp_rd(to_resp_rd),
        .resp_data(to_resp_data), .resp_err(to_resp_err),
        .bus_req(to_bus_req), .bus_we(to_bus_we), .bus_addr(to_bus_addr), .bus_be(to_bus_be),
        .bus_wdata(to_bus_wdata), .bus_gnt(to_gnt), .bus_rvalid(bus_rvalid),
        .bus_rdata(bus_rdata)
    );

    typedef struct {
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        int          gnt_cyc;    // cycle after accept in which gnt is high (0 = never)
        int          rv_cyc;     // cycle after accept in which rvalid is high (0 = never)
        logic [31:0] rdata;
        logic        exp_bus;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        int          exp_lat;
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
        logic [1:0]  exp_err;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs[NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Runs one request from a negedge; returns at a negedge one cycle after RESP
    task automatic do_txn(input vec_t v, input int idx);
        int   cyc;
        int   lat;
        bit   got;
        bit   seen_bus;
        bit   bus_ok;
        bit   stall_ok;
        logic [4:0]  g_rd;
        logic [31:0] g_data;
        logic [1:0]  g_err;
        req_valid  = 1'b1;
        req_write  = v.wr;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        req_rd     = v.rd;
        bus_rdata  = v.rdata;
        #1;
        check($sformatf("v%0d_stall_accept", idx), {31'h0, stall}, 32'h1);
        @(posedge clock);
        cyc = 0; lat = 0; got = 0; seen_bus = 0; bus_ok = 1; stall_ok = 1;
        g_rd = 5'd0; g_data = 32'h0; g_err = 2'd0;
        while (!got && cyc < 40) begin
            @(negedge clock);
            cyc++;
            if (resp_valid) begin
                got = 1; lat = cyc;
                g_rd = resp_rd; g_data = resp_data; g_err = resp_err;
                if (stall !== 1'b0) stall_ok = 0;
                if (bus_req !== 1'b0) bus_ok = 0;
            end else begin
                if (stall !== 1'b1) stall_ok = 0;
                if (bus_req === 1'b1) begin
                    seen_bus = 1;
                    if (bus_addr !== v.exp_addr || bus_be !== v.exp_be ||
                        bus_wdata !== v.exp_wdata || bus_we !== v.wr) bus_ok = 0;
                end
            end
            bus_gnt    = (cyc == v.gnt_cyc);
            bus_rvalid = (cyc == v.rv_cyc);
        end
        bus_gnt = 1'b0; bus_rvalid = 1'b0;
        check($sformatf("v%0d_latency", idx), lat, v.exp_lat);
        check($sformatf("v%0d_resp_rd", idx), {27'h0, g_rd}, {27'h0, v.exp_rd});
        check($sformatf("v%0d_resp_data", idx), g_data, v.exp_data);
        check($sformatf("v%0d_resp_err", idx), {30'h0, g_err}, {30'h0, v.exp_err});
        check($sformatf("v%0d_bus_seen", idx), {31'h0, seen_bus}, {31'h0, v.exp_bus});
        check($sformatf("v%0d_bus_fields", idx), {31'h0, bus_ok}, 32'h1);
        check($sformatf("v%0d_stall", idx), {31'h0, stall_ok}, 32'h1);
        @(negedge clock);
        req_valid = 1'b0;
        #1;
        check($sformatf("v%0d_back_idle", idx), {30'h0, resp_valid, bus_req}, 32'h0);
        $display("txn %0d: wr=%0d f3=%0d addr=%h lat=%0d rd=%0d data=%h err=%0d",
                 idx, v.wr, v.f3, v.addr, lat, g_rd, g_data, g_err);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   breq;
        int   nresp;
        int   lat;
        bit   main_resp;
        logic [1:0]  t_err;
        logic [4:0]  t_rd;
        logic [31:0] t_data;

        // wr, f3, addr, wdata, rd, gnt, rv, rdata, bus, baddr, be, bwdata, lat, rd, data, err
        vecs[0]  = '{1'b1, 3'b000, 32'h13, 32'h0000_00AB, 5'd5, 1, 0, 32'h0,
                     1'b1, 32'h10, 4'b1000, 32'hABAB_ABAB, 2, 5'd0, 32'h0, 2'd0};
        vecs[1]  = '{1'b0, 3'b000, 32'h21, 32'h0, 5'd7, 1, 2, 32'h0000_F000,
                     1'b1, 32'h20, 4'b0010, 32'h0, 3, 5'd7, 32'hFFFF_FFF0, 2'd0};
        vecs[2]  = '{1'b0, 3'b100, 32'h21, 32'h0, 5'd7, 1, 2, 32'h0000_F000,
                     1'b1, 32'h20, 4'b0010, 32'h0, 3, 5'd7, 32'h0000_00F0, 2'd0};
        vecs[3]  = '{1'b0, 3'b001, 32'h03, 32'h0, 5'd8, 0, 0, 32'h0,
                     1'b0, 32'h0, 4'b0000, 32'h0, 1, 5'd0, 32'h0, 2'd1};
        vecs[4]  = '{1'b0, 3'b011, 32'h00, 32'h0, 5'd8, 0, 0, 32'h0,
                     1'b0, 32'h0, 4'b0000, 32'h0, 1, 5'd0, 32'h0, 2'd2};
        vecs[5]  = '{1'b0, 3'b010, 32'h40, 32'h0, 5'd9, 6, 7, 32'h1234_5678,
                     1'b1, 32'h40, 4'b1111, 32'h0, 8, 5'd9, 32'h1234_5678, 2'd0};
        vecs[6]  = '{1'b0, 3'b001, 32'h22, 32'h0, 5'd3, 1, 1, 32'h8001_0000,
                     1'b1, 32'h20, 4'b1100, 32'h0, 2, 5'd3, 32'hFFFF_8001, 2'd0};
        vecs[7]  = '{1'b0, 3'b101, 32'h22, 32'h0, 5'd4, 2, 4, 32'h8001_0000,
                     1'b1, 32'h20, 4'b1100, 32'h0, 5, 5'd4, 32'h0000_8001, 2'd0};
        vecs[8]  = '{1'b1, 3'b001, 32'h06, 32'hDEAD_BEEF, 5'd2, 1, 0, 32'h0,
                     1'b1, 32'h04, 4'b1100, 32'hBEEF_BEEF, 2, 5'd0, 32'h0, 2'd0};
        vecs[9]  = '{1'b1, 3'b010, 32'h0C, 32'hCAFE_F00D, 5'd1, 3, 0, 32'h0,
                     1'b1, 32'h0C, 4'b1111, 32'hCAFE_F00D, 4, 5'd0, 32'h0, 2'd0};
        vecs[10] = '{1'b0, 3'b010, 32'h42, 32'h0, 5'd1, 0, 0, 32'h0,
                     1'b0, 32'h0, 4'b0000, 32'h0, 1, 5'd0, 32'h0, 2'd1};
        vecs[11] = '{1'b0, 3'b000, 32'h07, 32'h0, 5'd0, 1, 2, 32'h8000_0000,
                     1'b1, 32'h04, 4'b1000, 32'h0, 3, 5'd0, 32'hFFFF_FF80, 2'd0};
        vecs[12] = '{1'b1, 3'b111, 32'h08, 32'h55, 5'd3, 0, 0, 32'h0,
                     1'b0, 32'h0, 4'b0000, 32'h0, 1, 5'd0, 32'h0, 2'd2};

        reset = 1'b1; req_valid = 1'b0; to_req_valid = 1'b0; to_gnt = 1'b0;
        req_write = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
        req_rd = 5'd0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;

        // reset state: every output low
        repeat (3) @(negedge clock);
        check("rst_ctrl", {28'h0, stall, resp_valid, bus_req, bus_we}, 32'h0);
        check("rst_bus_addr", bus_addr, 32'h0);
        check("rst_bus_be_err_rd", {21'h0, bus_be, resp_err, resp_rd}, 32'h0);
        check("rst_data", bus_wdata | resp_data, 32'h0);

        // stray rvalid right after reset release
        reset = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        @(negedge clock);
        bus_rvalid = 1'b0;
        @(negedge clock);
        check("stray_rvalid", {30'h0, resp_valid, to_resp_valid}, 32'h0);

        for (int i = 0; i < NVEC; i++) do_txn(vecs[i], i);

        // timeout on the TIMEOUT=4 instance, gnt never given
        req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100; req_rd = 5'd6;
        to_req_valid = 1'b1;
        @(posedge clock);
        breq = 0; nresp = 0; lat = 0; main_resp = 0;
        t_err = 2'd0; t_rd = 5'd0; t_data = 32'h0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clock);
            if (to_bus_req === 1'b1) breq++;
            if (resp_valid === 1'b1) main_resp = 1;
            if (to_resp_valid === 1'b1) begin
                if (nresp == 0) begin
                    lat = c; t_err = to_resp_err; t_rd = to_resp_rd; t_data = to_resp_data;
                end
                nresp++;
            end
            if (c == 6) to_req_valid = 1'b0;
            bus_rvalid = (c == 7);
            bus_rdata  = 32'h5A5A_5A5A;
        end
        bus_rvalid = 1'b0;
        check("to_bus_req_cycles", breq, 4);
        check("to_latency", lat, 5);
        check("to_err", {30'h0, t_err}, 32'd3);
        check("to_rd_data", {t_rd, 27'h0} | t_data, 32'h0);
        check("to_single_resp", nresp, 1);
        check("to_main_quiet", {31'h0, main_resp}, 32'h0);
        $display("txn timeout: bus_req_cycles=%0d lat=%0d err=%0d resp_pulses=%0d", breq, lat, t_err, nresp);

        // reset while waiting for read data
        req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h80; req_rd = 5'd11;
        req_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("rw_issue", {30'h0, bus_req, stall}, 32'h3);
        bus_gnt = 1'b1;
        @(negedge clock);
        bus_gnt = 1'b0;
        check("rw_wait", {30'h0, bus_req, stall}, 32'h1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0; req_valid = 1'b0;
        #1;
        check("rw_after_reset", {29'h0, stall, bus_req, resp_valid}, 32'h0);
        bus_rvalid = 1'b1; bus_rdata = 32'h1111_2222;
        main_resp = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            bus_rvalid = 1'b0;
            if (resp_valid === 1'b1 || bus_req === 1'b1) main_resp = 1;
        end
        check("rw_rvalid_ignored", {31'h0, main_resp}, 32'h0);
        $display("txn reset_in_wait: quiet=%0d", !main_resp);
        do_txn(vecs[9], 99);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lsu_mem_unit.md
Name: lsu_mem_unit

Overview:
- Parametrised load/store unit that replaces the word-only MEM-stage data access of the 5-stage RV32I core.
- Accepts one memory request from the EX/MEM pipeline register and supports LB/LH/LW/LBU/LHU/SB/SH/SW with byte-lane masking and sign/zero extension.
- Accesses data memory over a req/gnt/rvalid bus with variable latency. Stalls the pipeline until completion, and reports misaligned, illegal or timed-out accesses.

Parameters:
ADDR_W, 32, byte-address width of req_addr and bus_addr
TIMEOUT, 16, maximum cycles spent in ISSUE+WAIT before abort; 0 disables the timeout
DATA_W, 32, data width; fixed at 32, other values are a synthesis error

Ports:
clock  in  1  core clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  memory instruction present in MEM stage
req_write  in  1  1=store, 0=load
req_funct3  in  3  RV32I funct3 of load/store
req_addr  in  ADDR_W  effective byte address
req_wdata  in  32  store data (rs2)
req_rd  in  5  load destination register
stall  out  1  freeze IF..EX/MEM registers
resp_valid  out  1  one-cycle completion pulse
resp_rd  out  5  writeback register; 0 for stores and faults
resp_data  out  32  extended load data; 0 for stores and faults
resp_err  out  2  0 ok, 1 misaligned, 2 illegal funct3, 3 timeout
bus_req  out  1  bus request, held until bus_gnt
bus_we  out  1  write enable
bus_addr  out  ADDR_W  word-aligned address (low 2 bits 0)
bus_be  out  4  byte enables
bus_wdata  out  32  lane-aligned write data
bus_gnt  in  1  request accepted this cycle
bus_rvalid  in  1  read data valid
bus_rdata  in  32  read word

Behaviour:
- Single clock. Reset is synchronous and active-high: state=IDLE; all outputs and the timeout counter are 0. Reset mid-transaction aborts it, with no resp_valid. Stray bus_rvalid after reset is ignored.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - On req_valid, capture all req_* fields and compute off=addr[1:0].
  - Illegal funct3 (011, 110, 111) -> RESP with err=2.
  - Misaligned access -> RESP with err=1. Misaligned means a halfword with off[0]=1, or a word with off!=0. No bus activity occurs for faults.
  - Otherwise -> ISSUE.
- ISSUE:
  - bus_req=1, with bus_addr/bus_we/bus_be/bus_wdata stable until bus_gnt.
  - On gnt: store -> RESP; load -> WAIT.
  - bus_gnt and bus_rvalid in the same cycle on a load -> RESP directly, with the data taken.
- WAIT: on bus_rvalid, register the extracted data -> RESP.
- RESP:
  - resp_valid=1 for exactly one cycle, then -> IDLE.
  - req_valid is ignored in this cycle, because it still carries the completed request.
- stall = (IDLE && req_valid) || ISSUE || WAIT. stall is 0 in RESP so the pipeline advances on that edge.
- Latency, measured from the accept edge to the resp_valid cycle:
  - Store with gnt in its first ISSUE cycle: 2 cycles.
  - Load with gnt and rvalid one cycle apart: 3 cycles.
  - Fault: 1 cycle.
- Timeout:
  - The counter clears on entry to ISSUE and increments each ISSUE/WAIT cycle.
  - When count==TIMEOUT-1 without completion: drop bus_req and go to RESP with err=3.
  - A late rvalid arriving in RESP or IDLE is discarded.
- Store lanes:
  - SB: be=0001<<off, wdata={4{wdata[7:0]}}.
  - SH: be=0011<<off, wdata={2{wdata[15:0]}}.
  - SW: be=1111.
- Load extract: shift rdata right by off*8.
  - LB/LH sign-extend bit 7/15.
  - LBU/LHU zero-extend.
  - LW is passed unchanged.
- resp_rd: req_rd for successful loads, including rd=0 (the bus access is still performed); 0 otherwise.

Decomposition:
- Shared defines header holds:
  - funct3 encodings (LB..SW);
  - resp_err codes;
  - FSM state encodings.
- One combinational sub-module, lsu_align, produces bus_be/bus_wdata from (funct3, off, wdata) and resp_data from (funct3, off, rdata). The FSM, capture registers and timeout counter stay in lsu_mem_unit.

Test Plan:
- SB at addr 0x13, wdata 0x000000AB, gnt on first cycle -> bus_addr 0x10, be 1000, wdata 0xABABABAB; resp_valid 2 cycles after accept, resp_rd 0, err 0.
- LB at 0x21, rdata 0x0000F000 via gnt, then rvalid one cycle later -> resp_data 0xFFFFFFF0. LBU at the same address -> resp_data 0x000000F0, resp_rd = req_rd.
- LH at 0x03 -> no bus_req, err 1, resp_valid 1 cycle after accept. Load with funct3 011 -> err 2.
- LW at 0x40 with gnt held low for 5 cycles -> bus_req and fields stable all 5 cycles; stall high throughout; completes correctly after gnt and rvalid.
- TIMEOUT=4, gnt never asserted -> bus_req drops after 4 cycles, err 3. An rvalid injected 2 cycles later -> no second resp_valid.
- reset asserted while in WAIT -> next cycle: IDLE, stall 0, bus_req 0; subsequent rvalid ignored; next SW completes normally.
